// File: rtl/fft_pkg.sv
// fft_pkg: controller state type and pipeline latency helper for fft_frame_ctrl.
package fft_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, WAIT, UNLOAD} state_t;
   function automatic int calc_lat(input int stages, input int bf_lat);
      return stages * bf_lat + 1;
   endfunction
endpackage

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: buffers one frame for an external FFT core, waits its latency, then streams the bins out.
// Optional FFT_CTRL_SCALE_EN: output bins are arithmetic-shifted right by STAGES.
module fft_frame_ctrl
   import fft_pkg::*;
#(
   parameter int N      = 16,
   parameter int W      = 16,
   parameter int STAGES = 4,
   parameter int BF_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [W-1:0]  in_real,
   input  logic signed [W-1:0]  in_im,
   output logic signed [W-1:0]  fft_x_real [0:N-1],
   output logic signed [W-1:0]  fft_x_im   [0:N-1],
   input  logic signed [W-1:0]  fft_X_real [0:N-1],
   input  logic signed [W-1:0]  fft_X_im   [0:N-1],
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [W-1:0]  out_real,
   output logic signed [W-1:0]  out_im,
   output logic [STAGES-1:0]    out_idx,
   output logic                 out_last,
   output logic                 busy,
   output logic                 frame_done
);
   localparam int LAT = calc_lat(STAGES, BF_LAT);
   localparam int CW  = $clog2(LAT + 1);
   state_t state, nxt;
   logic [STAGES-1:0] wr_idx, rd_idx;
   logic [CW-1:0] wait_cnt;
   logic signed [W-1:0] obuf_re [0:N-1];
   logic signed [W-1:0] obuf_im [0:N-1];
   logic acc, xfer, cap;
   assign in_ready   = state == IDLE || state == LOAD;
   assign acc        = in_valid && in_ready;
   assign out_valid  = state == UNLOAD;
   assign xfer       = out_valid && out_ready;
   assign out_last   = out_valid && rd_idx == STAGES'(N - 1);
   assign frame_done = xfer && out_last;
   assign busy       = state != IDLE;
   assign cap        = state == WAIT && wait_cnt == CW'(LAT - 1);
   assign out_idx    = rd_idx;
`ifdef FFT_CTRL_SCALE_EN
   assign out_real = obuf_re[rd_idx] >>> STAGES;
   assign out_im   = obuf_im[rd_idx] >>> STAGES;
`else
   assign out_real = obuf_re[rd_idx];
   assign out_im   = obuf_im[rd_idx];
`endif
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:   nxt = acc ? LOAD : IDLE;
         LOAD:   nxt = (acc && wr_idx == STAGES'(N - 1)) ? WAIT : LOAD;
         WAIT:   nxt = cap ? UNLOAD : WAIT;
         UNLOAD: nxt = frame_done ? IDLE : UNLOAD;
         default: nxt = IDLE;
      endcase
   end
   // Indices are STAGES bits wide, so they wrap back to 0 at the end of each frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         wr_idx   <= '0;
         rd_idx   <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= nxt;
         wr_idx   <= acc ? wr_idx + 1'b1 : wr_idx;
         rd_idx   <= xfer ? rd_idx + 1'b1 : rd_idx;
         wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
      end
   end
   // Data buffers are never reset; a discarded frame is simply overwritten.
   always_ff @(posedge clk) begin
      if (acc) begin
         fft_x_real[wr_idx] <= in_real;
         fft_x_im[wr_idx]   <= in_im;
      end
      if (cap) begin
         obuf_re <= fft_X_real;
         obuf_im <= fft_X_im;
      end
   end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: random frames through fft_frame_ctrl with a pipelined DFT core,
// checked against a frame-level model (sample list -> DFT -> expected bin queue).
module tb_fft_frame_ctrl;
   localparam int N = 16, W = 16, ST = 4, CORE_LAT = 4, LAT = 5;
`ifdef FFT_CTRL_SCALE_EN
   localparam int IMP = 62;
`else
   localparam int IMP = 1000;
`endif
   logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
   logic signed [W-1:0] in_real = 0, in_im = 0;
   logic signed [W-1:0] fx_re [0:N-1], fx_im [0:N-1], fX_re [0:N-1], fX_im [0:N-1];
   logic in_ready, out_valid, out_last, busy, frame_done;
   logic signed [W-1:0] out_real, out_im;
   logic [ST-1:0] out_idx;
   int n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   fft_frame_ctrl #(.N(N), .W(W), .STAGES(ST), .BF_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_real(in_real), .in_im(in_im), .fft_x_real(fx_re), .fft_x_im(fx_im),
      .fft_X_real(fX_re), .fft_X_im(fX_im), .out_valid(out_valid), .out_ready(out_ready),
      .out_real(out_real), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
      .busy(busy), .frame_done(frame_done)
   );
   task automatic chk(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic int rnd(input real v);
      return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
   endfunction
   function automatic void dft(input logic signed [W-1:0] xr [0:N-1], input logic signed [W-1:0] xi [0:N-1],
                               output logic signed [W-1:0] yr [0:N-1], output logic signed [W-1:0] yi [0:N-1]);
      real sr, si, th;
      for (int k = 0; k < N; k++) begin
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < N; n++) begin
            th = 2.0 * 3.141592653589793 * real'((k * n) % N) / real'(N);
            sr += real'(xr[n]) * $cos(th) + real'(xi[n]) * $sin(th);
            si += real'(xi[n]) * $cos(th) - real'(xr[n]) * $sin(th);
         end
         yr[k] = W'(rnd(sr));
         yi[k] = W'(rnd(si));
      end
   endfunction
   // FFT core stand-in: exact DFT with CORE_LAT registered stages.
   logic signed [W-1:0] pre [0:CORE_LAT-1][0:N-1], pim [0:CORE_LAT-1][0:N-1];
   logic signed [W-1:0] tr [0:N-1], ti [0:N-1];
   always @(posedge clk) begin
      dft(fx_re, fx_im, tr, ti);
      pre[0] <= tr;
      pim[0] <= ti;
      for (int s = 1; s < CORE_LAT; s++) begin
         pre[s] <= pre[s-1];
         pim[s] <= pim[s-1];
      end
   end
   always_comb begin
      fX_re = pre[CORE_LAT-1];
      fX_im = pim[CORE_LAT-1];
   end
   typedef struct {logic signed [W-1:0] re, im; int idx;} bin_t;
   bin_t expq[$];
   logic signed [W-1:0] sr [0:N-1], si [0:N-1], yr [0:N-1], yi [0:N-1];
   int nsamp = 0, cyc = 0, first_due = 0, done_cyc = -10, run = 0;
   bit armed = 0, gap_chk = 0, imp = 0, stall = 0, vld_at_done = 0;
   logic signed [W-1:0] st_re, st_im;
   logic [ST-1:0] st_idx;
   int mode = 0;
   always @(negedge clk) begin
      bit e_rdy, e_busy, e_vld;
      bin_t b;
      cyc++;
      e_rdy  = expq.size() == 0;
      e_busy = nsamp > 0 || expq.size() > 0;
      e_vld  = expq.size() > 0 && cyc >= first_due;
      if (armed) begin
         chk("busy", busy, e_busy);
         chk("in_ready", in_ready, e_rdy);
         chk("out_valid", out_valid, e_vld);
         if (e_vld) begin
            b = expq[0];
            chk("out_real", out_real, b.re);
            chk("out_im", out_im, b.im);
            chk("out_idx", out_idx, b.idx);
            chk("out_last", out_last, b.idx == N - 1);
            chk("frame_done", frame_done, out_ready && b.idx == N - 1);
            if (imp) begin
               chk("imp_re", out_real, IMP);
               chk("imp_im", out_im, 0);
            end
         end else begin
            chk("idle_last", out_last, 0);
            chk("idle_done", frame_done, 0);
         end
         if (stall) begin
            chk("stall_re", out_real, st_re);
            chk("stall_im", out_im, st_im);
            chk("stall_idx", out_idx, st_idx);
         end
         if (!in_ready) run++;
         else begin
            if (run > 0 && gap_chk) chk("ready_gap", run, LAT + N);
            run = 0;
         end
      end
      if (!rst_n) begin
         nsamp = 0;
         expq.delete();
         stall = 0;
         run = 0;
      end else begin
         stall = e_vld && !out_ready;
         st_re = out_real;
         st_im = out_im;
         st_idx = out_idx;
         if (e_vld && out_ready) begin
            if (expq[0].idx == N - 1) begin
               done_cyc = cyc;
               vld_at_done = in_valid;
            end
            void'(expq.pop_front());
         end
         if (in_valid && e_rdy) begin
            if (nsamp == 0 && vld_at_done) begin
               chk("resume", cyc, done_cyc + 1);
               vld_at_done = 0;
            end
            sr[nsamp] = in_real;
            si[nsamp] = in_im;
            nsamp++;
            if (nsamp == N) begin
               dft(sr, si, yr, yi);
               for (int k = 0; k < N; k++) begin
`ifdef FFT_CTRL_SCALE_EN
                  expq.push_back('{yr[k] >>> ST, yi[k] >>> ST, k});
`else
                  expq.push_back('{yr[k], yi[k], k});
`endif
               end
               first_due = cyc + 1 + LAT;
               nsamp = 0;
            end
         end
      end
   end
   always @(posedge clk) begin
      #1;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~out_ready : 1'($urandom_range(0, 1));
   end
   task automatic push(input logic signed [W-1:0] r, input logic signed [W-1:0] i, input bit hold);
      bit a = 0;
      int t = 0;
      in_valid = 1;
      in_real = r;
      in_im = i;
      while (!a && t < 100) begin
         @(negedge clk);
         a = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      chk("accept", a, 1);
      if (!hold) in_valid = 0;
   endtask
   function automatic logic signed [W-1:0] rs();
      return W'(int'($urandom_range(0, 2000)) - 1000);
   endfunction
   task automatic frame(input bit im, input bit hold);
      imp = im;
      for (int n = 0; n < N; n++) begin
         if (im) push(n == 0 ? W'(1000) : W'(0), W'(0), hold);
         else push(rs(), rs(), hold);
         if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
   endtask
   task automatic wait_idle();
      int t = 0;
      while ((busy || expq.size() > 0) && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain", t < 300, 1);
      @(posedge clk);
      #1;
      imp = 0;
   endtask
   initial begin
      @(posedge clk);
      #1;
      armed = 1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      gap_chk = 1;
      frame(1, 0);
      wait_idle();
      mode = 1;
      gap_chk = 0;
      frame(0, 0);
      wait_idle();
      mode = 2;
      repeat (3) begin
         frame(0, 0);
         wait_idle();
      end
      mode = 0;
      gap_chk = 1;
      for (int n = 0; n < 9; n++) push(rs(), rs(), 0);
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      frame(1, 0);
      wait_idle();
      frame(0, 1);
      frame(0, 1);
      in_valid = 0;
      wait_idle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter N, default 16: FFT points; power of 2, at least 2.
REQ-002 Parameter W, default 16: sample width, signed two's complement.
REQ-003 Parameter STAGES, default 4: log2(N).
REQ-004 Parameter BF_LAT, default 1: clock cycles of latency per butterfly stage.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 in_valid  in  1  input sample offered.
REQ-008 in_ready  out  1  controller accepts an input sample.
REQ-009 in_real, in_im  in  W each  input sample, natural order.
REQ-010 fft_x_real, fft_x_im  out  unpacked [0:N-1] of W each  frame driven to the FFT core.
REQ-011 fft_X_real, fft_X_im  in  unpacked [0:N-1] of W each  FFT core results.
REQ-012 out_valid  out  1  output bin offered.
REQ-013 out_ready  in  1  downstream accepts the output bin.
REQ-014 out_real, out_im  out  W each  output bin value.
REQ-015 out_idx  out  STAGES  bin index of the current output.
REQ-016 out_last  out  1  high with bin N-1.
REQ-017 busy  out  1  state is not IDLE.
REQ-018 frame_done  out  1  one-cycle pulse on the final output transfer.

Function
REQ-019 States SHALL be IDLE, LOAD, WAIT and UNLOAD.
REQ-020 in_ready SHALL be 1 in IDLE and LOAD and 0 otherwise; a sample is accepted when in_valid and in_ready are both 1.
REQ-021 An accepted sample SHALL be written to input buffer slot wr_idx, then wr_idx SHALL increment.
REQ-022 An accept in IDLE SHALL write slot 0 and move to LOAD with wr_idx=1.
REQ-023 An accept in LOAD with wr_idx=N-1 SHALL move to WAIT with wr_idx=0 and wait_cnt=0.
REQ-024 fft_x_* SHALL be driven directly from the input buffer registers, which SHALL hold during WAIT and UNLOAD.
REQ-025 LAT SHALL equal STAGES*BF_LAT+1; the +1 is the input-register settle cycle.
REQ-026 In WAIT, wait_cnt SHALL increment each cycle.
REQ-027 At the edge where wait_cnt==LAT-1, all fft_X_* SHALL be captured into the output buffer and the state SHALL move to UNLOAD with rd_idx=0; WAIT lasts exactly LAT cycles.
REQ-028 In UNLOAD, out_valid SHALL be 1 and out_real/out_im/out_idx SHALL present output buffer slot rd_idx.
REQ-029 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 On each output transfer, rd_idx SHALL increment.
REQ-031 On the transfer with rd_idx=N-1, out_last and frame_done SHALL be 1 and the state SHALL return to IDLE.
REQ-032 No input is accepted in WAIT or UNLOAD; frames SHALL NOT overlap.
REQ-033 in_valid asserted in the same cycle as the final output transfer SHALL NOT be accepted; it SHALL be accepted in the following IDLE cycle.
REQ-034 out_valid, out_last and frame_done SHALL be 0 outside UNLOAD.

Reset
REQ-035 rst_n=0 at any clock edge, including mid-operation, SHALL force IDLE, wr_idx=0, rd_idx=0 and wait_cnt=0.
REQ-036 Reset SHALL drive out_valid=0, frame_done=0, busy=0 and in_ready=1 after the edge.
REQ-037 Any partial frame SHALL be discarded; buffer contents are not cleared and SHALL NOT be observable until overwritten.

Configuration
REQ-038 With macro FFT_CTRL_SCALE_EN defined, out_real/out_im SHALL be the buffered value arithmetic-shifted right by STAGES (floor rounding).
REQ-039 Without FFT_CTRL_SCALE_EN, out_real/out_im SHALL be the buffered value unmodified.

Structure
REQ-040 Package fft_pkg SHALL hold the state enum type and a function computing LAT from STAGES and BF_LAT.
REQ-041 No sub-module is instantiated; the fft core is instantiated beside the controller at top level and wired through fft_x_*/fft_X_*.

Verification
(All scenarios use N=16, W=16, STAGES=4, BF_LAT=1, so LAT=5.)
REQ-042 Impulse: in_real[0]=1000, all other samples 0, out_ready=1 -> 16 bins, each real=1000 and im=0; first out_valid occurs exactly 5 cycles after the 16th accept.
REQ-043 With FFT_CTRL_SCALE_EN and the same impulse -> every bin real=62, im=0.
REQ-044 Backpressure: out_ready toggling 1,0,1,0 -> out_idx 0..15 each delivered once, fields stable while stalled, out_last only with idx 15, single frame_done pulse.
REQ-045 Reset after 9 accepted samples -> busy=0 and in_ready=1 next cycle; a new impulse frame then yields all bins 1000.
REQ-046 Continuous in_valid=1 across two frames -> in_ready=0 for exactly 5+16 cycles per frame with out_ready=1; the second frame's first sample is accepted the cycle after frame_done.
